// File: rtl/mem_access_unit_if.sv
// Request and writeback handshakes of the MEM-stage load/store unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (
    output req_valid,
    output req_store,
    output req_size,
    output req_unsigned,
    output req_addr,
    output req_wdata,
    output req_rd,
    input  req_ready,
    input  wb_valid,
    input  wb_rd,
    input  wb_data,
    output wb_ready
  );

  modport slave (
    input  req_valid,
    input  req_store,
    input  req_size,
    input  req_unsigned,
    input  req_addr,
    input  req_wdata,
    input  req_rd,
    output req_ready,
    output wb_valid,
    output wb_rd,
    output wb_data,
    input  wb_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller in front of the byte-addressed data RAM.
// Raises AdEL/AdES on misaligned or out-of-range accesses.
module mem_access_unit #(
  parameter int ADDR_SIZE   = 8,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic              clk,
  input  logic              CLR_n,
  mem_access_unit_if.slave  bus,
  input  logic              clr_req,
  output logic              clr_done,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_data_in,
  output logic              ram_MemWrite,
  output logic              ram_Byte,
  output logic              ram_Half,
  output logic              ram_UnsignedExt,
  output logic              ram_CLR,
  input  logic [31:0]       ram_data_out,
  output logic              exc_valid,
  output logic [4:0]        exc_code,
  output logic [31:0]       exc_badvaddr
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    WB_HOLD,
    CLEAR
  } state_t;

  typedef struct packed {
    logic [1:0] size;
    logic       uns;
  } ld_t;

  state_t      state, state_nxt;
  ld_t         ld_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        accept;
  logic        misalign;
  logic        out_range;
  logic        fault;
  logic        go;

  function automatic logic [31:0] extend(
    input logic [31:0] d,
    input ld_t         l
  );
    logic [31:0] r;
    unique case (1'b1)
      l.size == 2'b00:
        r = {{24{~l.uns & d[7]}}, d[7:0]};
      l.size == 2'b01:
        r = {{16{~l.uns & d[15]}}, d[15:0]};
      default:
        r = d;
    endcase
    return r;
  endfunction

  assign bus.req_ready = (state == IDLE) && !clr_req;
  assign accept = CLR_n && bus.req_valid
               && bus.req_ready;

  assign misalign =
    ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
    (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

  // Shift rather than slice so ADDR_SIZE may be any width up to 32.
  assign out_range = CHECK_RANGE &&
    ((bus.req_addr >> ADDR_SIZE) != 32'd0);

  assign fault = misalign || out_range;
  assign go    = accept && !fault;

  assign clr_done     = (state == CLEAR);
  assign bus.wb_valid = (state == WB_HOLD);

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ram_addr        = addr_q;
    ram_data_in     = wdata_q;
    ram_MemWrite    = 1'b0;
    ram_Byte        = 1'b0;
    ram_Half        = 1'b0;
    ram_UnsignedExt = 1'b0;
    ram_CLR         = 1'b0;
    unique case (state)
      IDLE: begin
        if (CLR_n && clr_req) begin
          ram_CLR   = 1'b1;
          state_nxt = CLEAR;
        end else if (go) begin
          ram_addr        = bus.req_addr;
          ram_data_in     = bus.req_wdata;
          ram_MemWrite    = bus.req_store;
          ram_Byte        = (bus.req_size == 2'b00);
          ram_Half        = (bus.req_size == 2'b01);
          ram_UnsignedExt = bus.req_unsigned;
          if (!bus.req_store) begin
            state_nxt = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: state_nxt = WB_HOLD;
      WB_HOLD: begin
        if (bus.wb_ready) begin
          state_nxt = IDLE;
        end
      end
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      ld_q         <= '0;
      bus.wb_rd    <= '0;
      bus.wb_data  <= '0;
      exc_valid    <= 1'b0;
      exc_code     <= '0;
      exc_badvaddr <= '0;
    end else begin
      exc_valid <= accept && fault;
      if (accept && fault) begin
        exc_code     <= bus.req_store ? 5'd5 : 5'd4;
        exc_badvaddr <= bus.req_addr;
      end
      if (go) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (go && !bus.req_store) begin
        ld_q.size <= bus.req_size;
        ld_q.uns  <= bus.req_unsigned;
        bus.wb_rd <= bus.req_rd;
      end
      if (state == LOAD_WAIT) begin
        bus.wb_data <= extend(ram_data_out, ld_q);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural RAM, byte-array reference
// model, directed corner cases and a randomized load/store mix.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic CLR_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  logic        clr_req;
  logic        clr_done;
  logic [31:0] ram_addr;
  logic [31:0] ram_data_in;
  logic        ram_MemWrite;
  logic        ram_Byte;
  logic        ram_Half;
  logic        ram_UnsignedExt;
  logic        ram_CLR;
  logic [31:0] ram_data_out;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(
    .ADDR_SIZE(8),
    .CHECK_RANGE(1'b1)
  ) dut (
    .clk(clk),
    .CLR_n(CLR_n),
    .bus(bus),
    .clr_req(clr_req),
    .clr_done(clr_done),
    .ram_addr(ram_addr),
    .ram_data_in(ram_data_in),
    .ram_MemWrite(ram_MemWrite),
    .ram_Byte(ram_Byte),
    .ram_Half(ram_Half),
    .ram_UnsignedExt(ram_UnsignedExt),
    .ram_CLR(ram_CLR),
    .ram_data_out(ram_data_out),
    .exc_valid(exc_valid),
    .exc_code(exc_code),
    .exc_badvaddr(exc_badvaddr)
  );

  // Data RAM: byte array, registered little-endian word read.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    logic [7:0] a;
    a = ram_addr[7:0];
    if (ram_CLR) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (ram_MemWrite) begin
      ram[a] <= ram_data_in[7:0];
      if (!ram_Byte) ram[a + 8'd1] <= ram_data_in[15:8];
      if (!ram_Byte && !ram_Half) begin
        ram[a + 8'd2] <= ram_data_in[23:16];
        ram[a + 8'd3] <= ram_data_in[31:24];
      end
    end
    ram_data_out <= {ram[a + 8'd3], ram[a + 8'd2],
                     ram[a + 8'd1], ram[a]};
  end

  // Reference memory contents as seen by the program.
  int unsigned mdl [256];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_fault(input logic [1:0] sz,
                                  input logic [31:0] a);
    return ((a % nbytes(sz)) != 0) || (a >= 32'd256);
  endfunction

  function automatic logic [31:0] model_load(
    input logic [1:0] sz, input bit un, input logic [31:0] a);
    int unsigned nb;
    longint v;
    nb = nbytes(sz);
    v = 0;
    for (int i = int'(nb) - 1; i >= 0; i--)
      v = v * 256 + longint'(mdl[(int'(a[7:0]) + i) % 256]);
    if (!un && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] sz,
                             input logic [31:0] a,
                             input logic [31:0] wd);
    for (int i = 0; i < int'(nbytes(sz)); i++)
      mdl[(int'(a[7:0]) + i) % 256] = (wd >> (8 * i)) & 32'hFF;
  endtask

  task automatic idle_inputs();
    bus.req_valid    = 1'b0;
    bus.req_store    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.req_rd       = 5'd0;
    bus.wb_ready     = 1'b0;
    clr_req          = 1'b0;
  endtask

  task automatic set_req(input bit st, input logic [1:0] sz,
                         input bit un, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
    bus.req_valid    = 1'b1;
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
  endtask

  // One complete transaction, including writeback with `hold`
  // cycles of back-pressure for loads.
  task automatic issue(input bit st, input logic [1:0] sz,
                       input bit un, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input int hold);
    bit          flt;
    int          n;
    logic [31:0] exp;
    flt = is_fault(sz, a);
    exp = model_load(sz, un, a);
    @(negedge clk);
    set_req(st, sz, un, a, wd, rd);
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    if (flt) begin
      chk("flt_memwrite", 32'(ram_MemWrite), 32'd0);
    end else begin
      chk("memwrite", 32'(ram_MemWrite), 32'(st));
      chk("byte", 32'(ram_Byte), 32'(sz == 2'd0));
      chk("half", 32'(ram_Half), 32'(sz == 2'd1));
      chk("ram_addr", ram_addr, a);
      if (st) chk("ram_wdata", ram_data_in, wd);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (flt) begin
      chk("exc_valid", 32'(exc_valid), 32'd1);
      chk("exc_code", 32'(exc_code), st ? 32'd5 : 32'd4);
      chk("exc_badvaddr", exc_badvaddr, a);
      chk("flt_no_wb", 32'(bus.wb_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("exc_pulse", 32'(exc_valid), 32'd0);
    end else if (st) begin
      model_store(sz, a, wd);
    end else begin
      n = 1;
      while (!bus.wb_valid && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("load_latency", 32'(n), 32'd2);
      chk("wb_rd", 32'(bus.wb_rd), 32'(rd));
      chk("wb_data", bus.wb_data, exp);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", 32'(bus.wb_valid), 32'd1);
        chk("hold_data", bus.wb_data, exp);
        chk("hold_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.wb_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.wb_ready = 1'b0;
      chk("wb_drop", 32'(bus.wb_valid), 32'd0);
    end
  endtask

  // Word load held off by writeback while a store waits upstream.
  task automatic load_held(input logic [31:0] a,
                           input logic [4:0] rd, input int hold,
                           input logic [31:0] qa,
                           input logic [31:0] qd);
    logic [31:0] exp;
    exp = model_load(2'd2, 1'b0, a);
    @(negedge clk);
    set_req(1'b0, 2'd2, 1'b0, a, 32'd0, rd);
    @(posedge clk);
    #1;
    set_req(1'b1, 2'd2, 1'b0, qa, qd, 5'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < hold; i++) begin
      chk("held_valid", 32'(bus.wb_valid), 32'd1);
      chk("held_data", bus.wb_data, exp);
      chk("held_rd", 32'(bus.wb_rd), 32'(rd));
      chk("held_stall", 32'(bus.req_ready), 32'd0);
      chk("held_nowrite", 32'(ram_MemWrite), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.wb_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.wb_ready = 1'b0;
    chk("held_wb_drop", 32'(bus.wb_valid), 32'd0);
    chk("queued_ready", 32'(bus.req_ready), 32'd1);
    chk("queued_write", 32'(ram_MemWrite), 32'd1);
    chk("queued_addr", ram_addr, qa);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    model_store(2'd2, qa, qd);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    chk({tag, "_exc_valid"}, 32'(exc_valid), 32'd0);
    chk({tag, "_clr_done"}, 32'(clr_done), 32'd0);
    chk({tag, "_wb_data"}, bus.wb_data, 32'd0);
    chk({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'd0);
    chk({tag, "_exc_code"}, 32'(exc_code), 32'd0);
    chk({tag, "_badvaddr"}, exc_badvaddr, 32'd0);
    chk({tag, "_ram_addr"}, ram_addr, 32'd0);
    chk({tag, "_ram_din"}, ram_data_in, 32'd0);
    chk({tag, "_strobes"},
        32'({ram_MemWrite, ram_Byte, ram_Half,
             ram_UnsignedExt, ram_CLR}), 32'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mdl[i] = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    CLR_n = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    // Word round trip and sign/zero extension.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5'd7, 0);
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h00000080, 5'd0, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h21, 32'd0, 5'd3, 0);
    issue(1'b0, 2'd0, 1'b1, 32'h21, 32'd0, 5'd4, 0);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 5'd0, 0);
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'd0, 5'd5, 0);
    issue(1'b0, 2'd1, 1'b1, 32'h22, 32'd0, 5'd6, 0);

    // Address errors.
    issue(1'b0, 2'd2, 1'b0, 32'h13, 32'd0, 5'd1, 0);
    issue(1'b1, 2'd1, 1'b0, 32'h05, 32'h1234, 5'd0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 5'd1, 0);

    // Back-pressured load with a store queued behind it.
    load_held(32'h10, 5'd9, 3, 32'h40, 32'hCAFEF00D);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 5'd10, 0);

    // Clear wins over a simultaneous request.
    @(negedge clk);
    clr_req = 1'b1;
    set_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5'd2);
    #1;
    chk("clr_strobe", 32'(ram_CLR), 32'd1);
    chk("clr_ready", 32'(bus.req_ready), 32'd0);
    chk("clr_nowrite", 32'(ram_MemWrite), 32'd0);
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    chk("clr_done", 32'(clr_done), 32'd1);
    chk("clr_wait", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("clr_done_pulse", 32'(clr_done), 32'd0);
    for (int i = 0; i < 256; i++) mdl[i] = 0;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5'd2, 0);

    // Reset with a load in flight.
    issue(1'b1, 2'd2, 1'b0, 32'h44, 32'h11223344, 5'd0, 0);
    @(negedge clk);
    set_req(1'b0, 2'd2, 1'b0, 32'h44, 32'd0, 5'd8);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    CLR_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(posedge clk);
    @(negedge clk);
    CLR_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    end
    chk_reset_vals("post");

    // Randomized mix.
    for (int k = 0; k < 300; k++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0)
        a = a & ~(32'(nbytes(sz)) - 32'd1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            a, $urandom, 5'($urandom_range(0, 31)),
            int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store controller sitting directly upstream of the byte-addressed data RAM.
- Accepts one load/store request per cycle from the EX/MEM pipeline register over a valid/ready handshake.
- Drives the RAM control pins (addr, data_in, MemWrite, Byte, Half, UnsignedExt_Mem, CLR) and captures the RAM's registered read data.
- Delivers loads to writeback over a valid/ready handshake and raises address-error exceptions for misaligned or out-of-range accesses.

Parameters:
- ADDR_SIZE, 8, number of RAM byte-address bits. RAM holds 2^ADDR_SIZE bytes.
- CHECK_RANGE, 1, when 1, any request with addr[31:ADDR_SIZE] != 0 raises an exception.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- CLR_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_unsigned  in  1  zero-extend loads (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  load destination register.
- clr_req  in  1  request a whole-RAM clear.
- clr_done  out  1  one-cycle pulse when the clear has completed.
- ram_addr  out  32  to RAM addr.
- ram_data_in  out  32  to RAM data_in.
- ram_MemWrite  out  1  to RAM MemWrite.
- ram_Byte  out  1  to RAM Byte.
- ram_Half  out  1  to RAM Half.
- ram_UnsignedExt  out  1  to RAM UnsignedExt_Mem.
- ram_CLR  out  1  to RAM CLR.
- ram_data_out  in  32  from RAM data_out; registered inside the RAM, valid one cycle after the access edge.
- wb_valid  out  1  load result valid.
- wb_ready  in  1  writeback consumes the result.
- wb_rd  out  5  destination register.
- wb_data  out  32  extended load data.
- exc_valid  out  1  one-cycle exception pulse.
- exc_code  out  5  4 = AdEL (load), 5 = AdES (store).
- exc_badvaddr  out  32  faulting address.

Behaviour:
- States:
  - IDLE: accepting requests.
  - LOAD_WAIT: RAM read in flight.
  - WB_HOLD: wb_valid high, waiting for wb_ready.
  - CLEAR: RAM clear in progress.
- req_ready = (state == IDLE) && !clr_req. Accept means req_valid && req_ready.
- Fault condition, evaluated only on accept:
  - half with addr[0] = 1, or word with addr[1:0] != 0; or
  - CHECK_RANGE = 1 and out-of-range upper address bits.
- Faulting request:
  - No RAM access: ram_MemWrite = 0, ram_CLR = 0.
  - Next cycle: exc_valid = 1 for one cycle; exc_code = 5 if store, else 4; exc_badvaddr = req_addr.
  - State stays IDLE.
- RAM drive is combinational during an accepted, non-faulting request cycle:
  - ram_addr = req_addr, ram_data_in = req_wdata.
  - ram_Byte = (size == 00), ram_Half = (size == 01).
  - ram_UnsignedExt = req_unsigned, ram_MemWrite = req_store.
- Outside accept cycles: ram_MemWrite = 0, ram_Byte = 0, ram_Half = 0, ram_CLR = 0. ram_addr and ram_data_in hold their last value; the RAM's idle reads are don't-care.
- Store: completes on the accept edge. No writeback. Back-to-back stores are sustained at 1 per cycle.
- Load:
  - Accept cycle T: unit registers rd, size, unsigned and addr; state goes to LOAD_WAIT.
  - Cycle T+1 (LOAD_WAIT): sample ram_data_out into wb_data at that cycle's edge, re-applying extension from the registered size and unsigned flags:
    - byte: bits [7:0], sign- or zero-extended;
    - half: bits [15:0], sign- or zero-extended;
    - word: pass-through.
    - Then go to WB_HOLD.
  - wb_valid is high from T+2. Load latency is 2 cycles.
  - WB_HOLD: wb_valid, wb_rd and wb_data are held stable until wb_valid && wb_ready, then IDLE. wb_valid = 0 the next cycle.
  - No new request is accepted during LOAD_WAIT or WB_HOLD.
- Clear:
  - In IDLE with clr_req = 1: ram_CLR = 1 combinationally for that cycle; clr_req has priority over req_valid.
  - State goes to CLEAR for one cycle, clr_done = 1 during that cycle, then IDLE.
- Reset (async, CLR_n = 0):
  - State → IDLE.
  - wb_valid = 0, exc_valid = 0, clr_done = 0.
  - wb_data = 0, wb_rd = 0, exc_code = 0, exc_badvaddr = 0, ram_addr = 0, ram_data_in = 0.
  - All RAM control strobes = 0 while reset is asserted.
  - An in-flight load is dropped; no wb_valid appears after reset.
- Simultaneous events:
  - clr_req with req_valid: clear wins, request waits.
  - Request arriving in LOAD_WAIT or WB_HOLD: stalled via req_ready = 0.
  - exc_valid pulse coinciding with a new accept in the next cycle is legal.

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word @0x10 → wb_valid at accept+2, wb_data = 0xDEADBEEF, wb_rd echoed.
- Store byte 0x80 @0x21: lb @0x21 → 0xFFFFFF80; lbu → 0x00000080. Store half 0x8001 @0x22: lh → 0xFFFF8001; lhu → 0x00008001.
- lw @0x13 → exc_valid 1 cycle, exc_code = 4, exc_badvaddr = 0x13, ram_MemWrite never 1. sh @0x05 → exc_code = 5. lw @0x100 with CHECK_RANGE = 1 → AdEL.
- Load completes with wb_ready held 0 for 3 cycles → wb_valid and wb_data stable, req_ready = 0 throughout; a queued store is accepted the cycle after the wb handshake.
- clr_req together with req_valid → ram_CLR = 1, clr_done next cycle, request accepted afterward; lw @0x10 then returns 0.
- Assert CLR_n = 0 during LOAD_WAIT → wb_valid stays 0 after release, req_ready = 1, all outputs at their reset values.
